rv32_decode_stage: RTL and testbench

//  Registered, parametrised RV32I(+M) decode pipeline stage between fetch and execute.

---
 rtl/rv32_decode_stage.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_stage.sv
// RV32I(+M) decode stage between fetch and execute; flags illegal encodings.
// Latency: 1 cycle from input accept to out_valid when the output register is free.
// Backpressure: a one-entry skid absorbs a stalled output; in_ready is simply "skid empty".
module rv32_decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_alu_sel,
   output logic             out_a_sel,
   output logic             out_b_sel,
   output logic [1:0]       out_wb_sel,
   output logic [2:0]       out_imm_sel,
   output logic             out_dmem_we,
   output logic [2:0]       out_dmem_mode,
   output logic             out_reg_we,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_is_branch,
   output logic [2:0]       out_br_funct3,
   output logic             out_br_un,
   output logic             out_is_jump,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_SRA = 5'd7;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      alu_sel;
      logic            a_sel;
      logic            b_sel;
      logic [1:0]      wb_sel;
      logic [2:0]      imm_sel;
      logic            dmem_we;
      logic [2:0]      dmem_mode;
      logic            reg_we;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic            is_branch;
      logic [2:0]      br_funct3;
      logic            br_un;
      logic            is_jump;
      logic            illegal;
   } bundle_t;

   // funct3 -> ALU op for the base (funct7 = 0) register/immediate forms
   function automatic logic [4:0] alu_base(input logic [2:0] f3);
      case (f3)
         3'd0:    alu_base = 5'd0;   // ADD
         3'd1:    alu_base = 5'd2;   // SLL
         3'd2:    alu_base = 5'd3;   // SLT
         3'd3:    alu_base = 5'd4;   // SLTU
         3'd4:    alu_base = 5'd5;   // XOR
         3'd5:    alu_base = 5'd6;   // SRL
         3'd6:    alu_base = 5'd8;   // OR
         default: alu_base = 5'd9;   // AND
      endcase
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   bundle_t    dec;

   bundle_t    out_q, out_d, skid_q, skid_d;
   logic       out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic in_fire, out_fire;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];

   // Combinational decode of the instruction currently presented by fetch
   always_comb begin
      legal   = 1'b1;
      dec     = '0;
      dec.pc  = in_pc;
      dec.rd  = in_inst[11:7];
      dec.rs1 = in_inst[19:15];
      dec.rs2 = in_inst[24:20];
      case (opcode)
         OP_R: begin
            dec.wb_sel = 2'd1;
            dec.reg_we = 1'b1;
            if (funct7 == 7'b0000000)                         dec.alu_sel = alu_base(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'd0)  dec.alu_sel = ALU_SUB;
            else if (funct7 == 7'b0100000 && funct3 == 3'd5)  dec.alu_sel = ALU_SRA;
            else if (ENABLE_M && funct7 == 7'b0000001)        dec.alu_sel = 5'd10 + 5'(funct3);
            else                                              legal = 1'b0;
         end
         OP_IMM: begin
            dec.b_sel  = 1'b1;
            dec.wb_sel = 2'd1;
            dec.reg_we = 1'b1;
            dec.alu_sel = alu_base(funct3);
            // Shift-immediates reuse funct7 as an opcode extension
            if (funct3 == 3'd1 && funct7 != 7'b0000000) legal = 1'b0;
            if (funct3 == 3'd5) begin
               if (funct7 == 7'b0100000)      dec.alu_sel = ALU_SRA;
               else if (funct7 != 7'b0000000) legal = 1'b0;
            end
         end
         OP_LOAD: begin
            dec.b_sel  = 1'b1;
            dec.reg_we = 1'b1;
            case (funct3)
               3'd0:    dec.dmem_mode = 3'd0;
               3'd1:    dec.dmem_mode = 3'd1;
               3'd2:    dec.dmem_mode = 3'd2;
               3'd4:    dec.dmem_mode = 3'd3;
               3'd5:    dec.dmem_mode = 3'd4;
               default: legal = 1'b0;
            endcase
         end
         OP_STORE: begin
            dec.b_sel     = 1'b1;
            dec.imm_sel   = 3'd1;
            dec.dmem_we   = 1'b1;
            dec.dmem_mode = funct3;
            if (funct3 > 3'd2) legal = 1'b0;
         end
         OP_BRANCH: begin
            dec.a_sel     = 1'b1;
            dec.b_sel     = 1'b1;
            dec.imm_sel   = 3'd2;
            dec.is_branch = 1'b1;
            dec.br_funct3 = funct3;
            dec.br_un     = funct3[1];
            if (funct3 == 3'd2 || funct3 == 3'd3) legal = 1'b0;
         end
         OP_JAL: begin
            dec.a_sel   = 1'b1;
            dec.b_sel   = 1'b1;
            dec.imm_sel = 3'd3;
            dec.wb_sel  = 2'd2;
            dec.is_jump = 1'b1;
            dec.reg_we  = 1'b1;
         end
         OP_JALR: begin
            dec.b_sel   = 1'b1;
            dec.wb_sel  = 2'd2;
            dec.is_jump = 1'b1;
            dec.reg_we  = 1'b1;
            if (funct3 != 3'd0) legal = 1'b0;
         end
         OP_LUI: begin
            // ALU computes x0 + U-immediate
            dec.b_sel   = 1'b1;
            dec.imm_sel = 3'd4;
            dec.wb_sel  = 2'd1;
            dec.reg_we  = 1'b1;
            dec.rs1     = 5'd0;
         end
         OP_AUIPC: begin
            dec.a_sel   = 1'b1;
            dec.b_sel   = 1'b1;
            dec.imm_sel = 3'd4;
            dec.wb_sel  = 2'd1;
            dec.reg_we  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      // Illegal bundles keep only PC and register indices for trap reporting
      if (!legal) begin
         dec         = '0;
         dec.pc      = in_pc;
         dec.rd      = in_inst[11:7];
         dec.rs1     = in_inst[19:15];
         dec.rs2     = in_inst[24:20];
         dec.illegal = 1'b1;
      end
      if (dec.rd == 5'd0) dec.reg_we = 1'b0;
   end

   assign in_ready = !skid_vld_q;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_vld_q && out_ready;

   // Output/skid steering and illegal counter next-state; flush overrides movement
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      cnt_d      = cnt_q;
      // A bundle killed by a same-cycle flush is not counted
      if (out_fire && out_q.illegal && !flush && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + CNT_W'(1);
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (out_vld_q && !out_ready) begin
         if (in_fire) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
         end
      end else if (skid_vld_q) begin
         // in_ready is low while skid is full, so no new input competes here
         out_d      = skid_q;
         out_vld_d  = 1'b1;
         skid_vld_d = 1'b0;
      end else if (in_fire) begin
         out_d     = dec;
         out_vld_d = 1'b1;
      end else begin
         out_vld_d = 1'b0;
      end
   end

   // Pipeline state registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid     = out_vld_q;
   assign out_pc        = out_q.pc;
   assign out_alu_sel   = out_q.alu_sel;
   assign out_a_sel     = out_q.a_sel;
   assign out_b_sel     = out_q.b_sel;
   assign out_wb_sel    = out_q.wb_sel;
   assign out_imm_sel   = out_q.imm_sel;
   assign out_dmem_we   = out_q.dmem_we;
   assign out_dmem_mode = out_q.dmem_mode;
   assign out_reg_we    = out_q.reg_we;
   assign out_rd        = out_q.rd;
   assign out_rs1       = out_q.rs1;
   assign out_rs2       = out_q.rs2;
   assign out_is_branch = out_q.is_branch;
   assign out_br_funct3 = out_q.br_funct3;
   assign out_br_un     = out_q.br_un;
   assign out_is_jump   = out_q.is_jump;
   assign out_illegal   = out_q.illegal;
   assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: table-driven stimulus with a scoreboard queue.
// Expected bundles are queued at input accept and compared at output accept.
// A second instance with the M extension enabled shadows the main one.
`timescale 1ns/1ps
module tb_rv32_decode_stage;

   typedef struct packed {
      logic [4:0] alu; logic a; logic b; logic [1:0] wb; logic [2:0] imm;
      logic dwe; logic [2:0] mode; logic rwe; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
      logic br; logic [2:0] bf3; logic bun; logic jmp; logic ill;
   } ctl_t;

   typedef struct {
      logic [31:0] pc;
      ctl_t        c;
      bit          mul;
   } sb_t;

   localparam int NT = 16;
   localparam logic [31:0] MUL_INST = 32'h022081B3;

   logic        clk = 1'b0;
   logic        reset_n, flush, in_valid, out_ready;
   logic [31:0] in_inst, in_pc;

   logic        in_ready, out_valid, out_a_sel, out_b_sel, out_dmem_we, out_reg_we;
   logic        out_is_branch, out_br_un, out_is_jump, out_illegal;
   logic [31:0] out_pc;
   logic [4:0]  out_alu_sel, out_rd, out_rs1, out_rs2;
   logic [1:0]  out_wb_sel;
   logic [2:0]  out_imm_sel, out_dmem_mode, out_br_funct3;
   logic [15:0] illegal_cnt;

   logic        m_in_ready, m_out_valid, m_a_sel, m_b_sel, m_dmem_we, m_reg_we;
   logic        m_is_branch, m_br_un, m_is_jump, m_illegal;
   logic [31:0] m_pc;
   logic [4:0]  m_alu_sel, m_rd, m_rs1, m_rs2;
   logic [1:0]  m_wb_sel;
   logic [2:0]  m_imm_sel, m_dmem_mode, m_br_funct3;
   logic [15:0] m_illegal_cnt;

   rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_alu_sel(out_alu_sel), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
      .out_wb_sel(out_wb_sel), .out_imm_sel(out_imm_sel), .out_dmem_we(out_dmem_we),
      .out_dmem_mode(out_dmem_mode), .out_reg_we(out_reg_we), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_is_branch(out_is_branch),
      .out_br_funct3(out_br_funct3), .out_br_un(out_br_un), .out_is_jump(out_is_jump),
      .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   rv32_decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut_m (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(m_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_pc),
      .out_alu_sel(m_alu_sel), .out_a_sel(m_a_sel), .out_b_sel(m_b_sel),
      .out_wb_sel(m_wb_sel), .out_imm_sel(m_imm_sel), .out_dmem_we(m_dmem_we),
      .out_dmem_mode(m_dmem_mode), .out_reg_we(m_reg_we), .out_rd(m_rd),
      .out_rs1(m_rs1), .out_rs2(m_rs2), .out_is_branch(m_is_branch),
      .out_br_funct3(m_br_funct3), .out_br_un(m_br_un), .out_is_jump(m_is_jump),
      .out_illegal(m_illegal), .illegal_cnt(m_illegal_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] t_inst [NT];
   ctl_t        t_exp  [NT];
   sb_t         sb [$];
   sb_t         cur;
   sb_t         head;
   logic [15:0] model_cnt = 16'd0;
   logic [31:0] pc_ctr = 32'h1000;
   bit          acc;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_table();
      t_inst[0]  = 32'h002081B3; t_exp[0]  = '{wb:2'd1, rwe:1'b1, rd:5'd3, rs1:5'd1, rs2:5'd2, default:0};          // ADD
      t_inst[1]  = 32'h0080A283; t_exp[1]  = '{b:1'b1, mode:3'd2, rwe:1'b1, rd:5'd5, rs1:5'd1, rs2:5'd8, default:0}; // LW
      t_inst[2]  = 32'h0050A423; t_exp[2]  = '{b:1'b1, imm:3'd1, dwe:1'b1, mode:3'd2, rd:5'd8, rs1:5'd1, rs2:5'd5, default:0}; // SW
      t_inst[3]  = MUL_INST;     t_exp[3]  = '{rd:5'd3, rs1:5'd1, rs2:5'd2, ill:1'b1, default:0};                   // MUL, no M
      t_inst[4]  = 32'h00001297; t_exp[4]  = '{a:1'b1, b:1'b1, imm:3'd4, wb:2'd1, rwe:1'b1, rd:5'd5, default:0};      // AUIPC
      t_inst[5]  = 32'h00000013; t_exp[5]  = '{b:1'b1, wb:2'd1, default:0};                                            // ADDI x0
      t_inst[6]  = 32'h0000007F; t_exp[6]  = '{ill:1'b1, default:0};                                                   // bad opcode
      t_inst[7]  = 32'h402081B3; t_exp[7]  = '{alu:5'd1, wb:2'd1, rwe:1'b1, rd:5'd3, rs1:5'd1, rs2:5'd2, default:0};  // SUB
      t_inst[8]  = 32'h40315213; t_exp[8]  = '{alu:5'd7, b:1'b1, wb:2'd1, rwe:1'b1, rd:5'd4, rs1:5'd2, rs2:5'd3, default:0}; // SRAI
      t_inst[9]  = 32'h0020E463; t_exp[9]  = '{a:1'b1, b:1'b1, imm:3'd2, br:1'b1, bf3:3'd6, bun:1'b1, rd:5'd8, rs1:5'd1, rs2:5'd2, default:0}; // BLTU
      t_inst[10] = 32'h010000EF; t_exp[10] = '{a:1'b1, b:1'b1, imm:3'd3, wb:2'd2, jmp:1'b1, rwe:1'b1, rd:5'd1, rs2:5'd16, default:0}; // JAL
      t_inst[11] = 32'h00009067; t_exp[11] = '{rs1:5'd1, ill:1'b1, default:0};                                        // JALR f3=1
      t_inst[12] = 32'h000100E7; t_exp[12] = '{b:1'b1, wb:2'd2, jmp:1'b1, rwe:1'b1, rd:5'd1, rs1:5'd2, default:0};   // JALR
      t_inst[13] = 32'h123453B7; t_exp[13] = '{b:1'b1, imm:3'd4, wb:2'd1, rwe:1'b1, rd:5'd7, rs2:5'd3, default:0};   // LUI
      t_inst[14] = 32'h0040C303; t_exp[14] = '{b:1'b1, mode:3'd3, rwe:1'b1, rd:5'd6, rs1:5'd1, rs2:5'd4, default:0}; // LBU
      t_inst[15] = 32'h0020A463; t_exp[15] = '{rd:5'd8, rs1:5'd1, rs2:5'd2, ill:1'b1, default:0};                     // branch f3=2
   endtask

   task automatic present(input int idx);
      in_inst = t_inst[idx];
      in_pc   = pc_ctr;
      cur.pc  = pc_ctr;
      cur.c   = t_exp[idx];
      cur.mul = (t_inst[idx] == MUL_INST);
   endtask

   task automatic cmp_bundle(input sb_t e);
      check_eq("pc",        out_pc,        e.pc);
      check_eq("alu_sel",   out_alu_sel,   e.c.alu);
      check_eq("a_sel",     out_a_sel,     e.c.a);
      check_eq("b_sel",     out_b_sel,     e.c.b);
      check_eq("wb_sel",    out_wb_sel,    e.c.wb);
      check_eq("imm_sel",   out_imm_sel,   e.c.imm);
      check_eq("dmem_we",   out_dmem_we,   e.c.dwe);
      check_eq("dmem_mode", out_dmem_mode, e.c.mode);
      check_eq("reg_we",    out_reg_we,    e.c.rwe);
      check_eq("rd",        out_rd,        e.c.rd);
      check_eq("rs1",       out_rs1,       e.c.rs1);
      check_eq("rs2",       out_rs2,       e.c.rs2);
      check_eq("is_branch", out_is_branch, e.c.br);
      check_eq("br_funct3", out_br_funct3, e.c.bf3);
      check_eq("br_un",     out_br_un,     e.c.bun);
      check_eq("is_jump",   out_is_jump,   e.c.jmp);
      check_eq("illegal",   out_illegal,   e.c.ill);
      if (e.mul) begin
         check_eq("m_alu_sel", m_alu_sel, 5'd10);
         check_eq("m_illegal", m_illegal, 1'b0);
         check_eq("m_reg_we",  m_reg_we,  1'b1);
      end
   endtask

   // One clock: monitor/scoreboard at negedge, then advance to just past the posedge
   task automatic tick();
      @(negedge clk);
      check_eq("illegal_cnt", illegal_cnt, model_cnt);
      if (out_valid) begin
         if (sb.size() == 0) begin
            check_eq("out_valid_unexpected", out_valid, 1'b0);
         end else begin
            head = sb[0];
            if (out_ready) begin
               cmp_bundle(head);
               void'(sb.pop_front());
               if (head.c.ill && !flush && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            end else begin
               check_eq("stall_pc", out_pc, head.pc);
               check_eq("stall_rd", out_rd, head.c.rd);
            end
         end
      end
      acc = in_valid && in_ready && !flush;
      if (flush) sb.delete();
      else if (acc) begin
         sb.push_back(cur);
         pc_ctr = pc_ctr + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx, input bit rand_rdy);
      int n = 0;
      acc = 1'b0;
      while (!acc && n < 64) begin
         present(idx);
         in_valid = 1'b1;
         if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
         tick();
         n++;
      end
      in_valid = 1'b0;
      check_eq("accept_timeout", acc, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      check_eq("drain_empty", sb.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int j;
      load_table();
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'h0; in_pc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready",  in_ready,  1'b1);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_pc",        out_pc,    32'h0);
      check_eq("rst_ctl", {out_alu_sel, out_a_sel, out_b_sel, out_wb_sel, out_imm_sel, out_dmem_we,
                           out_dmem_mode, out_reg_we, out_rd, out_rs1, out_rs2, out_is_branch,
                           out_br_funct3, out_br_un, out_is_jump, out_illegal}, 39'h0);
      check_eq("rst_cnt", illegal_cnt, 16'h0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // Single-cycle latency on an empty stage
      present(0); in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check_eq("latency_out_valid", out_valid, 1'b1);
      check_eq("latency_rd", out_rd, 5'd3);
      drain();

      // Full table back-to-back, then again with random output stalls
      for (int i = 0; i < NT; i++) begin out_ready = 1'b1; send(i, 1'b0); end
      drain();
      for (int i = 0; i < NT; i++) send(i, 1'b1);
      drain();

      // Three stalled cycles with four pending inputs: only two fit
      j = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         present(7 + j); in_valid = 1'b1;
         tick();
         if (acc) j++;
      end
      check_eq("bp_accepts", j, 2);
      check_eq("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      while (j < 4) begin send(7 + j, 1'b0); j++; end
      drain();

      // Flush with output and skid full plus a same-cycle input
      out_ready = 1'b0;
      send(12, 1'b0);
      send(13, 1'b0);
      present(14); in_valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check_eq("flush_out_valid", out_valid, 1'b0);
      check_eq("flush_in_ready",  in_ready,  1'b1);
      out_ready = 1'b1;
      repeat (3) tick();
      send(1, 1'b0);
      drain();

      // Asynchronous reset in the middle of a stalled stream
      out_ready = 1'b0;
      send(6, 1'b0);
      send(2, 1'b0);
      reset_n = 1'b0;
      #1;
      check_eq("arst_out_valid", out_valid, 1'b0);
      check_eq("arst_in_ready",  in_ready,  1'b1);
      check_eq("arst_cnt",       illegal_cnt, 16'h0);
      sb.delete();
      model_cnt = 16'd0;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) tick();

      // Saturate the illegal counter
      out_ready = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         present(6); in_valid = 1'b1;
         tick();
      end
      drain();
      check_eq("cnt_sat", illegal_cnt, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
